// File: rtl/vexriscv_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vexriscv_bus_arbiter_if
// Brief    : VexRiscv iBus/dBus command+response and shared memory bus bundle.
// Revision : 1.0
// ============================================================================
interface vexriscv_bus_arbiter_if;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready;
    logic [31:0] iBus_rsp_inst;
    logic        iBus_rsp_error;

    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic [31:0] dBus_rsp_data;
    logic        dBus_rsp_error;

    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_wr;
    logic [31:0] mem_cmd_address;
    logic [31:0] mem_cmd_data;
    logic [1:0]  mem_cmd_size;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_error;

    // Arbiter side
    modport slave (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_inst, iBus_rsp_error,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
               dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data, dBus_rsp_error,
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_address, mem_cmd_data, mem_cmd_size,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error
    );

    // CPU + memory side
    modport master (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_inst, iBus_rsp_error,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
               dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data, dBus_rsp_error,
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_address, mem_cmd_data, mem_cmd_size,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/vexriscv_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vexriscv_bus_arbiter
// Brief    : Shares one in-order memory port between VexRiscv iBus and dBus.
//            VEXRISCV_ARB_ROUND_ROBIN_EN selects round-robin (else dBus wins).
// Revision : 1.0
// ============================================================================
module vexriscv_bus_arbiter #(
    parameter int PEND_DEPTH = 4
) (
    input  wire logic                        clock,
    input  wire logic                        resetn,
    vexriscv_bus_arbiter_if.slave            bus,
    output logic [$clog2(PEND_DEPTH):0]      pending_count,
    output logic                             protocol_err
);
    localparam int PW = $clog2(PEND_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [PW:0]           r_count;
    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [PEND_DEPTH-1:0] r_tags;
    logic                  r_protoErr;

    logic w_full, w_empty;
    logic w_iElig, w_dElig, w_pickD;
    logic w_grantI, w_grantD;
    logic w_accept, w_push, w_pop, w_headTag;

`ifdef VEXRISCV_ARB_ROUND_ROBIN_EN
    logic r_prioD;
`endif

    assign w_full   = (r_count == (PW+1)'(PEND_DEPTH));
    assign w_empty  = (r_count == '0);
    // Full blocks new reads even if a response pops this cycle: no bypass.
    assign w_iElig  = bus.iBus_cmd_valid && !w_full;
    assign w_dElig  = bus.dBus_cmd_valid && (bus.dBus_cmd_payload_wr || !w_full);

`ifdef VEXRISCV_ARB_ROUND_ROBIN_EN
    assign w_pickD  = w_dElig && (!w_iElig || r_prioD);
`else
    assign w_pickD  = w_dElig;
`endif

    always_comb begin
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                w_grantD = w_pickD;
                w_grantI = w_iElig && !w_pickD;
                if (!bus.mem_cmd_ready) begin
                    if (w_grantD)      w_nextState = HOLD_D;
                    else if (w_grantI) w_nextState = HOLD_I;
                end
            end
            HOLD_I: begin
                w_grantI = 1'b1;
                if (bus.mem_cmd_ready) w_nextState = IDLE;
            end
            HOLD_D: begin
                w_grantD = 1'b1;
                if (bus.mem_cmd_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        // Keep every valid quiet while reset is held, not just after the edge.
        if (!resetn) begin
            w_grantI = 1'b0;
            w_grantD = 1'b0;
        end
    end

    assign bus.mem_cmd_valid   = w_grantI || w_grantD;
    assign bus.mem_cmd_wr      = w_grantD && bus.dBus_cmd_payload_wr;
    assign bus.mem_cmd_address = w_grantD ? bus.dBus_cmd_payload_address :
                                 w_grantI ? bus.iBus_cmd_payload_pc : 32'd0;
    assign bus.mem_cmd_data    = w_grantD ? bus.dBus_cmd_payload_data : 32'd0;
    assign bus.mem_cmd_size    = w_grantD ? bus.dBus_cmd_payload_size :
                                 w_grantI ? 2'b10 : 2'b00;
    assign bus.iBus_cmd_ready  = w_grantI && bus.mem_cmd_ready;
    assign bus.dBus_cmd_ready  = w_grantD && bus.mem_cmd_ready;

    assign w_accept  = bus.mem_cmd_valid && bus.mem_cmd_ready;
    assign w_push    = w_accept && !bus.mem_cmd_wr;
    assign w_pop     = bus.mem_rsp_valid && !w_empty;
    assign w_headTag = r_tags[r_rdPtr];

    assign bus.iBus_rsp_ready = w_pop && !w_headTag;
    assign bus.dBus_rsp_ready = w_pop &&  w_headTag;
    assign bus.iBus_rsp_inst  = bus.iBus_rsp_ready ? bus.mem_rsp_data  : 32'd0;
    assign bus.iBus_rsp_error = bus.iBus_rsp_ready && bus.mem_rsp_error;
    assign bus.dBus_rsp_data  = bus.dBus_rsp_ready ? bus.mem_rsp_data  : 32'd0;
    assign bus.dBus_rsp_error = bus.dBus_rsp_ready && bus.mem_rsp_error;

    assign pending_count = r_count;
    assign protocol_err  = r_protoErr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_tags     <= '0;
            r_protoErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_push) begin
                r_tags[r_wrPtr] <= w_grantD;
                r_wrPtr         <= r_wrPtr + 1'b1;
            end
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (bus.mem_rsp_valid && w_empty)
                r_protoErr <= 1'b1;
        end
    end

`ifdef VEXRISCV_ARB_ROUND_ROBIN_EN
    // r_prioD set means dBus wins the next conflict.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_prioD <= 1'b1;
        else if (w_accept)
            r_prioD <= w_grantI;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vexriscv_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vexriscv_bus_arbiter
// Brief    : Directed self-checking bench for vexriscv_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_vexriscv_bus_arbiter;
    localparam int PEND_DEPTH = 4;

    logic       clock;
    logic       resetn;
    logic [2:0] pendingCount;
    logic       protocolErr;
    int         vectors;
    int         miscompares;

    vexriscv_bus_arbiter_if bus();

    vexriscv_bus_arbiter #(.PEND_DEPTH(PEND_DEPTH)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .bus           (bus),
        .pending_count (pendingCount),
        .protocol_err  (protocolErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clearInputs();
        bus.iBus_cmd_valid           = 1'b0;
        bus.iBus_cmd_payload_pc      = 32'd0;
        bus.dBus_cmd_valid           = 1'b0;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'd0;
        bus.dBus_cmd_payload_data    = 32'd0;
        bus.dBus_cmd_payload_size    = 2'b00;
        bus.mem_cmd_ready            = 1'b0;
        bus.mem_rsp_valid            = 1'b0;
        bus.mem_rsp_data             = 32'd0;
        bus.mem_rsp_error            = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        resetn = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clearInputs();
        resetn = 1'b0;

        // Reset state, with requests already pending during reset
        bus.iBus_cmd_valid = 1'b1;
        bus.mem_cmd_ready  = 1'b1;
        #3;
        check("rst_mem_valid", 32'(bus.mem_cmd_valid), 32'd0);
        check("rst_i_ready", 32'(bus.iBus_cmd_ready), 32'd0);
        check("rst_pending", 32'(pendingCount), 32'd0);
        check("rst_proto_err", 32'(protocolErr), 32'd0);
        check("rst_rsp_strobes", 32'({bus.iBus_rsp_ready, bus.dBus_rsp_ready}), 32'd0);
        doReset();

        // Conflict in IDLE: dBus write vs iBus read, memory always ready
        bus.iBus_cmd_valid           = 1'b1;
        bus.iBus_cmd_payload_pc      = 32'h0000_1000;
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b1;
        bus.dBus_cmd_payload_address = 32'h0000_0200;
        bus.dBus_cmd_payload_data    = 32'h0000_00A5;
        bus.dBus_cmd_payload_size    = 2'b10;
        bus.mem_cmd_ready            = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic expI;
`ifdef VEXRISCV_ARB_ROUND_ROBIN_EN
            expI = (k % 2) == 1;
`else
            expI = 1'b0;
`endif
            #1;
            check("conf_mem_valid", 32'(bus.mem_cmd_valid), 32'd1);
            check("conf_addr", bus.mem_cmd_address, expI ? 32'h0000_1000 : 32'h0000_0200);
            check("conf_d_ready", 32'(bus.dBus_cmd_ready), 32'(!expI));
            check("conf_i_ready", 32'(bus.iBus_cmd_ready), 32'(expI));
            tick();
        end
        doReset();

        // Stalled dBus read holds payload while iBus arrives
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'h0000_0100;
        bus.dBus_cmd_payload_size    = 2'b10;
        #1;
        check("hold_c0_valid", 32'(bus.mem_cmd_valid), 32'd1);
        check("hold_c0_addr", bus.mem_cmd_address, 32'h0000_0100);
        check("hold_c0_d_ready", 32'(bus.dBus_cmd_ready), 32'd0);
        tick();
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h0000_2000;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("hold_addr", bus.mem_cmd_address, 32'h0000_0100);
            check("hold_wr", 32'(bus.mem_cmd_wr), 32'd0);
            check("hold_i_ready", 32'(bus.iBus_cmd_ready), 32'd0);
            tick();
        end
        bus.mem_cmd_ready = 1'b1;
        #1;
        check("hold_acc_d_ready", 32'(bus.dBus_cmd_ready), 32'd1);
        check("hold_acc_i_ready", 32'(bus.iBus_cmd_ready), 32'd0);
        check("hold_acc_addr", bus.mem_cmd_address, 32'h0000_0100);
        tick();
        bus.dBus_cmd_valid = 1'b0;
        #1;
        check("hold_pend1", 32'(pendingCount), 32'd1);
        check("hold_next_addr", bus.mem_cmd_address, 32'h0000_2000);
        check("hold_next_size", 32'(bus.mem_cmd_size), 32'd2);
        check("hold_next_i_ready", 32'(bus.iBus_cmd_ready), 32'd1);
        tick();
        check("hold_pend2", 32'(pendingCount), 32'd2);
        doReset();

        // Fill the tag FIFO with iBus reads
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h0000_3000;
        bus.mem_cmd_ready       = 1'b1;
        repeat (4) tick();
        #1;
        check("full_pend", 32'(pendingCount), 32'd4);
        check("full_i_blocked", 32'(bus.iBus_cmd_ready), 32'd0);
        check("full_mem_valid", 32'(bus.mem_cmd_valid), 32'd0);
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b1;
        bus.dBus_cmd_payload_address = 32'h0000_0400;
        #1;
        check("full_wr_valid", 32'(bus.mem_cmd_valid), 32'd1);
        check("full_wr_wr", 32'(bus.mem_cmd_wr), 32'd1);
        check("full_wr_d_ready", 32'(bus.dBus_cmd_ready), 32'd1);
        tick();
        bus.dBus_cmd_payload_wr = 1'b0;
        #1;
        check("full_pend_after_wr", 32'(pendingCount), 32'd4);
        check("full_rd_blocked", 32'(bus.dBus_cmd_ready), 32'd0);
        bus.dBus_cmd_valid = 1'b0;
        bus.mem_rsp_valid  = 1'b1;
        bus.mem_rsp_data   = 32'hDEAD_BEEF;
        #1;
        check("full_rsp_i_strobe", 32'(bus.iBus_rsp_ready), 32'd1);
        check("full_rsp_inst", bus.iBus_rsp_inst, 32'hDEAD_BEEF);
        check("full_rsp_d_strobe", 32'(bus.dBus_rsp_ready), 32'd0);
        check("full_pop_no_bypass", 32'(bus.iBus_cmd_ready), 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check("full_pend3", 32'(pendingCount), 32'd3);
        check("full_i_reopen", 32'(bus.iBus_cmd_ready), 32'd1);
        bus.iBus_cmd_valid = 1'b0;
        doReset();

        // In-order routing of responses by tag
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h0000_0010;
        bus.mem_cmd_ready       = 1'b1;
        tick();
        bus.iBus_cmd_valid           = 1'b0;
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_address = 32'h0000_0020;
        #1;
        check("ord_d_ready", 32'(bus.dBus_cmd_ready), 32'd1);
        tick();
        bus.dBus_cmd_valid = 1'b0;
        #1;
        check("ord_pend2", 32'(pendingCount), 32'd2);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0011;
        #1;
        check("ord_rsp1_i", 32'(bus.iBus_rsp_ready), 32'd1);
        check("ord_rsp1_inst", bus.iBus_rsp_inst, 32'h0000_0011);
        check("ord_rsp1_d", 32'(bus.dBus_rsp_ready), 32'd0);
        check("ord_rsp1_ddata", bus.dBus_rsp_data, 32'd0);
        tick();
        bus.mem_rsp_data  = 32'h0000_0022;
        bus.mem_rsp_error = 1'b1;
        #1;
        check("ord_rsp2_d", 32'(bus.dBus_rsp_ready), 32'd1);
        check("ord_rsp2_data", bus.dBus_rsp_data, 32'h0000_0022);
        check("ord_rsp2_err", 32'(bus.dBus_rsp_error), 32'd1);
        check("ord_rsp2_i", 32'(bus.iBus_rsp_ready), 32'd0);
        check("ord_rsp2_inst", bus.iBus_rsp_inst, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_error = 1'b0;
        #1;
        check("ord_pend0", 32'(pendingCount), 32'd0);
        check("ord_no_err", 32'(protocolErr), 32'd0);

        // Simultaneous push and pop keeps the count
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h0000_0040;
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0055;
        #1;
        check("pp_i_ready", 32'(bus.iBus_cmd_ready), 32'd1);
        check("pp_rsp", 32'(bus.iBus_rsp_ready), 32'd1);
        tick();
        bus.iBus_cmd_valid = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        #1;
        check("pp_pend", 32'(pendingCount), 32'd1);
        doReset();

        // Orphan response
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0077;
        #1;
        check("orph_strobes", 32'({bus.iBus_rsp_ready, bus.dBus_rsp_ready}), 32'd0);
        check("orph_inst", bus.iBus_rsp_inst, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check("orph_err_set", 32'(protocolErr), 32'd1);
        repeat (3) tick();
        check("orph_err_sticky", 32'(protocolErr), 32'd1);
        doReset();
        #1;
        check("orph_err_cleared", 32'(protocolErr), 32'd0);

        // Reset with reads outstanding discards them
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h0000_0080;
        bus.mem_cmd_ready       = 1'b1;
        repeat (2) tick();
        check("mid_pend2", 32'(pendingCount), 32'd2);
        resetn = 1'b0;
        #1;
        check("mid_async_pend", 32'(pendingCount), 32'd0);
        check("mid_async_valid", 32'(bus.mem_cmd_valid), 32'd0);
        doReset();
        bus.mem_rsp_valid = 1'b1;
        #1;
        check("mid_late_strobe", 32'(bus.iBus_rsp_ready), 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check("mid_late_err", 32'(protocolErr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vexriscv_bus_arbiter.md
VEXRISCV_BUS_ARBITER -- requirements
Module: vexriscv_bus_arbiter

Interface
REQ-001 SHALL have parameter PEND_DEPTH, default 4, depth of the outstanding-read tag FIFO (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports iBus_cmd_valid in 1, iBus_cmd_ready out 1, iBus_cmd_payload_pc in 32  VexRiscv instruction fetch command.
REQ-005 SHALL have ports iBus_rsp_ready out 1, iBus_rsp_inst out 32, iBus_rsp_error out 1  fetch response (rsp_ready is a one-cycle valid strobe).
REQ-006 SHALL have ports dBus_cmd_valid in 1, dBus_cmd_ready out 1, dBus_cmd_payload_wr in 1, dBus_cmd_payload_address in 32, dBus_cmd_payload_data in 32, dBus_cmd_payload_size in 2  data command.
REQ-007 SHALL have ports dBus_rsp_ready out 1, dBus_rsp_data out 32, dBus_rsp_error out 1  data read response strobe.
REQ-008 SHALL have ports mem_cmd_valid out 1, mem_cmd_ready in 1, mem_cmd_wr out 1, mem_cmd_address out 32, mem_cmd_data out 32, mem_cmd_size out 2  shared memory command.
REQ-009 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in 32, mem_rsp_error in 1  shared memory response, in command order.
REQ-010 SHALL have outputs pending_count out clog2(PEND_DEPTH)+1 (reads outstanding) and protocol_err out 1 (sticky).

Function
REQ-011 SHALL implement grant FSM states IDLE, HOLD_I, HOLD_D.
REQ-012 IDLE: if a requester is eligible, SHALL drive mem_cmd_valid combinationally from the winner; on mem_cmd_ready same cycle the transfer completes and FSM stays IDLE; otherwise FSM moves to HOLD_I/HOLD_D.
REQ-013 HOLD_x: SHALL keep granting x with stable payload until mem_cmd_ready, then return to IDLE; the other requester SHALL see cmd_ready=0.
REQ-014 iBus payload SHALL map to wr=0, address=pc, data=0, size=2'b10.
REQ-015 Requester eligibility: writes always eligible; reads (all iBus, dBus with wr=0) eligible only when tag FIFO not full; full-with-simultaneous-pop SHALL still block (no bypass).
REQ-016 Granted requester's cmd_ready SHALL equal mem_cmd_ready; non-granted cmd_ready SHALL be 0.
REQ-017 Each accepted read SHALL push a 1-bit source tag (0=iBus, 1=dBus) in the accept cycle; writes push nothing.
REQ-018 mem_rsp_valid with FIFO non-empty SHALL pop head and, same cycle (zero latency), assert iBus_rsp_ready or dBus_rsp_ready per tag with data/error forwarded.
REQ-019 mem_rsp_valid with FIFO empty SHALL be dropped (no rsp strobe) and set protocol_err until reset.
REQ-020 Simultaneous push and pop SHALL leave pending_count unchanged; pointers SHALL wrap modulo PEND_DEPTH.
REQ-021 rsp data outputs SHALL be mem_rsp_data/mem_rsp_error when corresponding strobe high, else 0.

Reset
REQ-022 resetn low SHALL immediately force FSM=IDLE, FIFO empty, pending_count=0, protocol_err=0, priority pointer=dBus, all strobes/valids low.
REQ-023 Reset mid-transfer or with reads outstanding SHALL discard them; responses arriving after deassertion SHALL set protocol_err.

Configuration
REQ-024 Macro VEXRISCV_ARB_ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-025 Defined: on IDLE conflict, winner SHALL be the requester not granted most recently (pointer updated on each completed transfer).
REQ-026 Undefined: dBus SHALL always win IDLE conflicts (fixed priority); pointer logic absent.

Verification
REQ-027 Both valid in IDLE, mem_cmd_ready=1, macro undefined -> dBus granted 3 consecutive cycles, iBus_cmd_ready=0 throughout.
REQ-028 Same with macro defined -> grants alternate D,I,D,I starting with dBus after reset.
REQ-029 dBus read addr 0x100 with mem_cmd_ready=0 for 3 cycles, iBus raises valid meanwhile -> mem_cmd payload stable at 0x100, FSM HOLD_D, iBus_cmd_ready=0 until acceptance.
REQ-030 Four iBus reads accepted (PEND_DEPTH=4), no response -> pending_count=4, fifth read blocked, dBus write still accepted; one rsp 0xDEADBEEF -> iBus_rsp_ready=1, inst=0xDEADBEEF, pending_count=3.
REQ-031 Reads I then D outstanding, responses 0x11 then 0x22 -> iBus gets 0x11, then dBus_rsp_data=0x22.
REQ-032 mem_rsp_valid with pending_count=0 -> no rsp strobe, protocol_err=1 until resetn pulse low.
